// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, bus encodings and
// the fixed kseg0/kseg1 address window.
package cpu_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_t;

  localparam logic [1:0]  INST_SIZE_WORD = 2'b10;
  localparam logic [31:0] KSEG_LO        = 32'h8000_0000;
  localparam logic [31:0] KSEG_HI        = 32'hBFFF_FFFF;
  localparam logic [31:0] KSEG_CLR_MASK  = 32'hE000_0000;
  localparam logic [31:0] RESET_PC       = 32'hBFC0_0000;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/if_addr_map.sv
// Fixed virtual-to-physical mapping: kseg0/kseg1 addresses lose bits [31:29],
// everything else passes straight through.
module if_addr_map
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAP_KSEG = 1
) (
  input  logic [WIDTH-1:0] vaddr,
  output logic [WIDTH-1:0] paddr
);

  localparam logic [WIDTH-1:0] LO  = WIDTH'(KSEG_LO);
  localparam logic [WIDTH-1:0] HI  = WIDTH'(KSEG_HI);
  localparam logic [WIDTH-1:0] CLR = WIDTH'(KSEG_CLR_MASK);

  logic in_kseg;

  always_comb begin
    in_kseg = (MAP_KSEG != 0) && (vaddr >= LO) && (vaddr <= HI);
    paddr   = in_kseg ? (vaddr & ~CLR) : vaddr;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: one outstanding word read per PC, valid/ready
// hand-off to decode, and flush-safe discard of in-flight fetches.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAP_KSEG = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_en,
  input  logic             flush,
  output logic             inst_req,
  output logic             inst_wr,
  output logic [1:0]       inst_size,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_inst,
  output logic             id_adel
);

  if_state_t        state_q, state_d;
  logic             discard_q, discard_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] id_pc_q, id_pc_d;
  logic [WIDTH-1:0] id_inst_q, id_inst_d;
  logic             id_adel_q, id_adel_d;
  logic [WIDTH-1:0] map_addr;

  if_addr_map #(
    .WIDTH    (WIDTH),
    .MAP_KSEG (MAP_KSEG)
  ) u_addr_map (
    .vaddr (pc_q),
    .paddr (map_addr)
  );

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    pc_d      = pc_q;
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    id_adel_d = id_adel_q;
    case (state_q)
      IF_IDLE: begin
        if (!flush) begin
          pc_d = pc;
          if (is_misaligned(pc[1:0])) begin
            state_d   = IF_HOLD;
            id_pc_d   = pc;
            id_inst_d = '0;
            id_adel_d = 1'b1;
          end else begin
            state_d = IF_REQ;
          end
        end
      end
      IF_REQ: begin
        if (flush) discard_d = 1'b1;
        if (inst_addr_ok) state_d = IF_WAIT;
      end
      IF_WAIT: begin
        // A flush landing on the data beat drops it just like a stored discard.
        if (inst_data_ok) begin
          if (discard_q || flush) begin
            discard_d = 1'b0;
            state_d   = IF_IDLE;
          end else begin
            id_inst_d = inst_rdata;
            id_pc_d   = pc_q;
            id_adel_d = 1'b0;
            state_d   = IF_HOLD;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      IF_HOLD: begin
        if (flush || id_ready) state_d = IF_IDLE;
      end
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IF_IDLE;
      discard_q <= 1'b0;
      pc_q      <= '0;
      id_pc_q   <= '0;
      id_inst_q <= '0;
      id_adel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      pc_q      <= pc_d;
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
      id_adel_q <= id_adel_d;
    end
  end

  // pc_en must fire in the accepting HOLD cycle so the PC register steps on
  // the same edge the FSM returns to IDLE; it never depends on read data.
  always_comb begin
    inst_req  = (state_q == IF_REQ);
    inst_wr   = 1'b0;
    inst_size = INST_SIZE_WORD;
    inst_addr = map_addr;
    id_valid  = (state_q == IF_HOLD);
    id_pc     = id_pc_q;
    id_inst   = id_inst_q;
    id_adel   = id_adel_q;
    pc_en     = (state_q == IF_HOLD) && id_ready && !flush;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed PCs, a latency-programmable
// memory responder, and a monitor that checks bus requests and decode hand-offs.
module tb_inst_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } dec_t;

  logic        clk;
  logic        resetn;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  int checks;
  int errors;
  int pc_en_cnt;
  int req_cnt;
  int dok_cnt;
  int en_base;
  int req_base;
  int dok_base;
  int addr_wait;
  int data_wait;
  logic [31:0] new_pc;

  logic [31:0] addr_q[$];
  dec_t        dec_q[$];

  inst_fetch #(
    .WIDTH    (32),
    .MAP_KSEG (1)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pc           (pc),
    .pc_en        (pc_en),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_adel      (id_adel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm, input logic [31:0] got);
    checks++;
    errors++;
    $display("FAIL %s got=%h exp=<none>", nm, got);
  endtask

  task automatic push_dec(input logic [31:0] p, input logic [31:0] i, input logic a);
    dec_t d;
    d.pc   = p;
    d.inst = i;
    d.adel = a;
    dec_q.push_back(d);
  endtask

  // Memory: addr_ok after addr_wait REQ cycles, data_ok data_wait cycles later.
  initial begin
    int          req_age;
    int          data_cnt;
    logic        data_pend;
    logic [31:0] data_addr;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    req_age      = 0;
    data_cnt     = 0;
    data_pend    = 1'b0;
    data_addr    = '0;
    forever begin
      @(posedge clk);
      #3;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = 32'hDEAD_BEEF;
      if (!resetn) begin
        req_age   = 0;
        data_pend = 1'b0;
      end else begin
        if (data_pend) begin
          if (data_cnt == 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = data_addr ^ 32'h5A5A_5A5A;
            data_pend    = 1'b0;
            dok_cnt++;
          end else begin
            data_cnt--;
          end
        end
        if (inst_req && !data_pend && !inst_data_ok) begin
          if (req_age >= addr_wait) begin
            inst_addr_ok = 1'b1;
            data_addr    = inst_addr;
            data_pend    = 1'b1;
            data_cnt     = data_wait;
            req_age      = 0;
          end else begin
            req_age++;
          end
        end
      end
    end
  end

  // Monitor: pops expectations on every bus accept and decode accept.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (pc_en) pc_en_cnt++;
        if (flush || !id_valid) chk("pc_en_idle", pc_en, 0);
        if (inst_req && inst_addr_ok) begin
          req_cnt++;
          chk("req_wr", inst_wr, 0);
          chk("req_size", inst_size, 2);
          if (addr_q.size() == 0) fail_now("unexpected_req", inst_addr);
          else chk("req_addr", inst_addr, addr_q.pop_front());
        end
        if (id_valid && id_ready && !flush) begin
          if (dec_q.size() == 0) begin
            fail_now("unexpected_decode", id_pc);
          end else begin
            dec_t e;
            e = dec_q.pop_front();
            chk("dec_pc", id_pc, e.pc);
            chk("dec_inst", id_inst, e.inst);
            chk("dec_adel", id_adel, e.adel);
          end
        end
      end
    end
  end

  // One clock with a PC-register model: flush loads new_pc, pc_en steps by 4.
  task automatic tick();
    logic en;
    logic fl;
    #1;
    en = pc_en;
    fl = flush;
    @(posedge clk);
    #2;
    if (fl) pc = new_pc;
    else if (en) pc = pc + 32'd4;
  endtask

  task automatic wait_valid(input string nm, output int n);
    n = 0;
    while (!id_valid && n < 40) begin
      tick();
      n++;
    end
    if (!id_valid) fail_now(nm, n);
  endtask

  task automatic wait_addr_ok(input string nm);
    int n;
    n = 0;
    do begin
      tick();
      #2;
      n++;
    end while (!inst_addr_ok && n < 40);
    if (!inst_addr_ok) fail_now(nm, n);
  endtask

  task automatic wait_data_ok(input string nm);
    int n;
    n = 0;
    do begin
      tick();
      #2;
      n++;
    end while (!inst_data_ok && n < 40);
    if (!inst_data_ok) fail_now(nm, n);
  endtask

  task automatic wait_accepts(input string nm, input int cnt);
    int n;
    n = 0;
    while ((pc_en_cnt - en_base) < cnt && n < 60) begin
      tick();
      n++;
    end
    if ((pc_en_cnt - en_base) < cnt) fail_now(nm, pc_en_cnt - en_base);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_req"}, inst_req, 0);
    chk({nm, "_valid"}, id_valid, 0);
    chk({nm, "_id_pc"}, id_pc, 0);
    chk({nm, "_id_inst"}, id_inst, 0);
    chk({nm, "_id_adel"}, id_adel, 0);
    chk({nm, "_pc_en"}, pc_en, 0);
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    chk("addr_q_drained", addr_q.size(), 0);
    chk("dec_q_drained", dec_q.size(), 0);
    addr_q.delete();
    dec_q.delete();
    resetn   = 1'b0;
    flush    = 1'b0;
    id_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    chk("rst_wr", inst_wr, 0);
    chk("rst_size", inst_size, 2);
    pc       = start_pc;
    en_base  = pc_en_cnt;
    req_base = req_cnt;
    dok_base = dok_cnt;
    resetn   = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=%0t exp=<finish>", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    pc_en_cnt = 0;
    req_cnt   = 0;
    dok_cnt   = 0;
    addr_wait = 0;
    data_wait = 0;
    new_pc    = '0;
    resetn    = 1'b0;
    flush     = 1'b0;
    id_ready  = 1'b0;
    pc        = 32'hBFC0_0000;

    // Zero-wait fetch from the reset vector, then a 5-cycle decode stall.
    do_reset(32'hBFC0_0000);
    addr_q.push_back(32'h1FC0_0000);
    addr_q.push_back(32'h1FC0_0004);
    push_dec(32'hBFC0_0000, 32'h459A_5A5A, 1'b0);
    id_ready = 1'b1;
    wait_valid("to_first_hold", n);
    chk("first_hold_cycle", n, 3);
    chk("pc_en_in_hold", pc_en, 1);
    chk("hold_id_pc", id_pc, 32'hBFC0_0000);
    tick();
    id_ready = 1'b0;
    chk("valid_after_accept", id_valid, 0);
    chk("pc_en_pulses_1", pc_en_cnt - en_base, 1);
    wait_valid("to_second_hold", n);
    chk("second_id_pc", id_pc, 32'hBFC0_0004);
    for (int i = 0; i < 5; i++) begin
      chk("stall_pc_en", pc_en, 0);
      chk("stall_req", inst_req, 0);
      chk("stall_valid", id_valid, 1);
      chk("stall_inst", id_inst, 32'h459A_5A5E);
      tick();
    end
    push_dec(32'hBFC0_0004, 32'h459A_5A5E, 1'b0);
    addr_q.push_back(32'h1FC0_0008);
    id_ready = 1'b1;
    #1;
    chk("pc_en_on_ready", pc_en, 1);
    tick();
    id_ready = 1'b0;
    wait_valid("to_third_hold", n);
    chk("third_id_pc", id_pc, 32'hBFC0_0008);
    chk("third_id_inst", id_inst, 32'h459A_5A52);
    chk("pc_en_pulses_2", pc_en_cnt - en_base, 2);

    // Flush in HOLD with ready high, redirecting to a misaligned PC (AdEL).
    flush    = 1'b1;
    new_pc   = 32'hBFC0_0002;
    id_ready = 1'b1;
    #1;
    chk("pc_en_flush_hold", pc_en, 0);
    tick();
    flush    = 1'b0;
    id_ready = 1'b0;
    chk("valid_after_flush", id_valid, 0);
    push_dec(32'hBFC0_0002, 32'h0, 1'b1);
    tick();
    chk("adel_valid", id_valid, 1);
    chk("adel_flag", id_adel, 1);
    chk("adel_inst", id_inst, 0);
    chk("adel_pc", id_pc, 32'hBFC0_0002);
    chk("adel_no_req", inst_req, 0);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk("pc_en_pulses_3", pc_en_cnt - en_base, 3);
    chk("req_count_3", req_cnt - req_base, 3);

    // Flush while waiting on slow data: the stale beat is dropped.
    addr_wait = 0;
    data_wait = 3;
    do_reset(32'hBFC0_0010);
    addr_q.push_back(32'h1FC0_0010);
    id_ready = 1'b1;
    wait_addr_ok("wait_flush_addr_ok");
    tick();
    chk("in_wait_no_req", inst_req, 0);
    flush     = 1'b1;
    new_pc    = 32'hBFC0_0100;
    data_wait = 0;
    tick();
    flush = 1'b0;
    addr_q.push_back(32'h1FC0_0100);
    push_dec(32'hBFC0_0100, 32'h459A_5B5A, 1'b0);
    wait_valid("to_hold_after_wait_flush", n);
    chk("wait_flush_id_pc", id_pc, 32'hBFC0_0100);
    chk("wait_flush_data_oks", dok_cnt - dok_base, 2);
    chk("wait_flush_no_pc_en", pc_en_cnt - en_base, 0);
    tick();
    chk("wait_flush_pc_en", pc_en_cnt - en_base, 1);

    // Flush coincident with addr_ok.
    addr_wait = 2;
    data_wait = 0;
    do_reset(32'hBFC0_0020);
    addr_q.push_back(32'h1FC0_0020);
    id_ready = 1'b1;
    wait_addr_ok("wait_addr_ok_flush");
    flush  = 1'b1;
    new_pc = 32'hBFC0_0200;
    tick();
    flush     = 1'b0;
    addr_wait = 0;
    addr_q.push_back(32'h1FC0_0200);
    push_dec(32'hBFC0_0200, 32'h459A_585A, 1'b0);
    wait_valid("to_hold_after_aok_flush", n);
    chk("aok_flush_id_pc", id_pc, 32'hBFC0_0200);
    chk("aok_flush_no_pc_en", pc_en_cnt - en_base, 0);
    tick();

    // Flush coincident with data_ok, then reset while a request is pending.
    data_wait = 2;
    do_reset(32'hBFC0_0030);
    addr_q.push_back(32'h1FC0_0030);
    id_ready = 1'b1;
    wait_addr_ok("wait_dok_flush_addr");
    wait_data_ok("wait_dok_flush_data");
    flush     = 1'b1;
    new_pc    = 32'hBFC0_0300;
    data_wait = 0;
    tick();
    flush = 1'b0;
    chk("dok_flush_valid", id_valid, 0);
    addr_q.push_back(32'h1FC0_0300);
    push_dec(32'hBFC0_0300, 32'h459A_595A, 1'b0);
    wait_valid("to_hold_after_dok_flush", n);
    chk("dok_flush_id_pc", id_pc, 32'hBFC0_0300);
    chk("dok_flush_no_pc_en", pc_en_cnt - en_base, 0);
    chk("dok_flush_data_oks", dok_cnt - dok_base, 2);
    tick();
    addr_wait = 100;
    tick();
    chk("pending_req", inst_req, 1);
    chk("pending_addr", inst_addr, 32'h1FC0_0304);
    chk("pending_id_pc", id_pc, 32'hBFC0_0300);
    resetn = 1'b0;
    tick();
    check_reset_outputs("mid_rst");
    resetn    = 1'b1;
    addr_wait = 0;
    pc        = 32'hBFC0_0040;
    en_base   = pc_en_cnt;
    addr_q.push_back(32'h1FC0_0040);
    push_dec(32'hBFC0_0040, 32'h459A_5A1A, 1'b0);
    wait_accepts("after_mid_reset", 1);

    // Mapping window boundaries.
    do_reset(32'h7FFF_FFFC);
    addr_q.push_back(32'h7FFF_FFFC);
    addr_q.push_back(32'h0000_0000);
    push_dec(32'h7FFF_FFFC, 32'h25A5_A5A6, 1'b0);
    push_dec(32'h8000_0000, 32'h5A5A_5A5A, 1'b0);
    id_ready = 1'b1;
    wait_accepts("kseg_low_edge", 2);
    do_reset(32'hBFFF_FFFC);
    addr_q.push_back(32'h1FFF_FFFC);
    addr_q.push_back(32'hC000_0000);
    push_dec(32'hBFFF_FFFC, 32'h45A5_A5A6, 1'b0);
    push_dec(32'hC000_0000, 32'h9A5A_5A5A, 1'b0);
    id_ready = 1'b1;
    wait_accepts("kseg_high_edge", 2);

    chk("final_addr_q", addr_q.size(), 0);
    chk("final_dec_q", dec_q.size(), 0);
    resetn   = 1'b0;
    id_ready = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage sitting directly downstream of the PC register. Samples the current PC, performs fixed kseg0/kseg1 address mapping, issues one word read on the SRAM-like instruction port, and presents the fetched instruction and its PC to the decode stage through a valid/ready handshake. It pulses `pc_en` to advance the PC only after decode accepts the instruction, and it cleanly discards in-flight fetches when the pipeline is flushed by a branch or exception redirect.

## Interface
- `WIDTH`, 32, address/data width
- `MAP_KSEG`, 1, when 1, addresses 0x8000_0000–0xBFFF_FFFF have bits [31:29] cleared; otherwise the address passes through unchanged
- `clk`  in  1  clock, rising-edge
- `resetn`  in  1  reset; one clock; reset is synchronous and active-low
- `pc`  in  WIDTH  current PC from the PC register
- `pc_en`  out  1  advance PC (drives PC `en`)
- `flush`  in  1  redirect this cycle (the PC register loads `newpc` on the same edge)
- `inst_req`  out  1  request valid
- `inst_wr`  out  1  constant 0
- `inst_size`  out  2  constant 2'b10 (word)
- `inst_addr`  out  WIDTH  mapped physical address
- `inst_addr_ok`  in  1  request accepted
- `inst_data_ok`  in  1  read data valid
- `inst_rdata`  in  WIDTH  read data
- `id_valid`  out  1  instruction held for decode
- `id_ready`  in  1  decode accepts
- `id_pc`  out  WIDTH  PC of the held instruction
- `id_inst`  out  WIDTH  instruction word (0 on AdEL)
- `id_adel`  out  1  fetch address error (`pc[1:0]` != 0)

## Operation
- States: IDLE, REQ, WAIT, HOLD. Flag `discard`.
- IDLE: if `flush` is asserted, stay in IDLE. Otherwise latch `pc` into `pc_q`.
  - If `pc[1:0]` != 0, go to HOLD with `id_adel`=1 and `id_inst`=0, and issue no request.
  - Otherwise go to REQ.
- REQ: assert `inst_req`, with `inst_addr` = map(`pc_q`) held stable. Once asserted, the request is never withdrawn. On `inst_addr_ok`, go to WAIT.
- WAIT: on `inst_data_ok`, capture `inst_rdata` into `id_inst`, set `id_pc` = `pc_q` and `id_adel` = 0, then go to HOLD. If `discard` is set, drop the data, clear `discard`, and go to IDLE.
- HOLD: `id_valid`=1. On `id_ready`, assert `pc_en`=1 for that cycle and go to IDLE.
- At most one outstanding transaction. Ignore `inst_data_ok` outside WAIT.
- Flush handling:
  - In REQ or WAIT: set `discard`. The transaction completes on the bus and its data is dropped.
  - `flush` together with `inst_addr_ok` in REQ: go to WAIT with `discard`=1.
  - `flush` together with `inst_data_ok` in WAIT: drop the data and go to IDLE.
  - In HOLD: drop the held instruction and go to IDLE with `id_valid`=0. `pc_en` is 0 even if `id_ready`=1.
- `pc_en` is never asserted in a cycle where `flush`=1.

## Timing
- Reset (`resetn`=0 at an edge): state=IDLE, `discard`=0, `inst_req`=0, `id_valid`=0, `id_pc`=0, `id_inst`=0, `id_adel`=0, `pc_en`=0.
- All outputs are registered or decoded from the state only. No combinational path from `inst_rdata` to `id_*`.
- Best case with zero-wait memory: IDLE (1) → REQ (1) → WAIT (1) → HOLD (1), which is 4 cycles per instruction. `pc_en` is high in the HOLD cycle, and the new PC appears in the following IDLE.
- AdEL path: IDLE → HOLD, 2 cycles.
- A reset asserted mid-transaction abandons the transaction. The memory side is reset by the same `resetn`.

## Structure
- Shared package `cpu_pkg`:
  - state enum `if_state_t`
  - `INST_SIZE_WORD` = 2'b10
  - `KSEG_LO` = 32'h8000_0000, `KSEG_HI` = 32'hBFFF_FFFF
  - `RESET_PC` = 32'hBFC0_0000
- One natural sub-module: `if_addr_map`, combinational virtual-to-physical mapping controlled by `MAP_KSEG`.

## Test plan
- Reset, then `pc`=0xBFC00000, memory returns `addr_ok` and `data_ok` each 1 cycle after the request, `id_ready`=1 → `inst_addr`=0x1FC00000; `id_valid` with `id_pc`=0xBFC00000 and `id_inst`=rdata in cycle 4; one `pc_en` pulse.
- `id_ready`=0 for 5 cycles in HOLD → outputs stable, `pc_en`=0, no new `inst_req`; `pc_en` pulses in the cycle `id_ready` rises.
- `pc`=0xBFC00002 → no `inst_req`; HOLD with `id_adel`=1 and `id_inst`=0 two cycles after IDLE.
- `flush` in WAIT with `data_ok` delayed 3 cycles → data dropped, `id_valid` stays 0, next request uses the new PC; exactly one `data_ok` consumed.
- `flush` coincident with `addr_ok`, and separately `flush` coincident with `data_ok` → neither instruction reaches decode, no `pc_en`.
- `resetn`=0 during REQ with `addr_ok` held low → next cycle `inst_req`=0 and all outputs at their reset values.
